// File: rtl/textlcd_responder.sv
// HD44780-style text LCD bus responder.
// Decodes host bus cycles into a 2x16 DDRAM model with busy timing.
module textlcd_responder #(
  parameter int SHORT_BUSY = 40,
  parameter int LONG_BUSY  = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic [6:0] addr_cnt,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       ovr_err
);

  localparam int CW = $clog2(LONG_BUSY + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic            fill_on;
  logic [4:0]      fill_idx;
  logic [7:0]      mem [32];

  logic            e_m, e_s, e_d;
  logic            rs_m, rs_s;
  logic            rw_m, rw_s;
  logic [7:0]      din_m, din_s;

  logic            strobe, wr_stb, rd_stb;
  logic            exec, dwr, drd, clr;
  logic            is_long, is_noop, go_busy;
  logic            map_ok;
  logic [4:0]      map_idx;
  logic [7:0]      rd_data;

  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       up
  );
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  assign busy    = (state_q != S_IDLE);
  assign strobe  = e_d & ~e_s;
  assign wr_stb  = strobe & ~rw_s;
  assign rd_stb  = strobe & rw_s;
  assign exec    = wr_stb & ~busy;
  assign dwr     = exec & rs_s;
  assign drd     = rd_stb & rs_s & ~busy;
  assign clr     = exec & ~rs_s & (din_s == 8'h01);
  assign is_long = (din_s[7:2] == 6'd0) & (din_s[1:0] != 2'd0);
  assign is_noop = ~rs_s & (din_s == 8'h00);
  assign go_busy = exec & ~is_noop;
  assign map_ok  = (addr_cnt[5:4] == 2'b00);
  assign map_idx = {addr_cnt[6], addr_cnt[3:0]};
  assign rd_data = map_ok ? mem[map_idx] : 8'h20;
  assign lcd_doe = e_s & rw_s;

  // two-flop synchronizers plus edge-detect delay on e
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_m   <= 1'b0;
      e_s   <= 1'b0;
      e_d   <= 1'b0;
      rs_m  <= 1'b0;
      rs_s  <= 1'b0;
      rw_m  <= 1'b0;
      rw_s  <= 1'b0;
      din_m <= 8'h00;
      din_s <= 8'h00;
    end else begin
      e_m   <= lcd_e;
      e_s   <= e_m;
      e_d   <= e_s;
      rs_m  <= lcd_rs;
      rs_s  <= rs_m;
      rw_m  <= lcd_rw;
      rw_s  <= rw_m;
      din_m <= lcd_din;
      din_s <= din_m;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // next-state: init fill, idle, timed busy
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: if (fill_idx == 5'd31) state_d = S_IDLE;
      S_IDLE: if (go_busy)           state_d = S_BUSY;
      S_BUSY: if (cnt == '0)         state_d = S_IDLE;
      default:                       state_d = S_INIT;
    endcase
  end

  // busy countdown, loaded on an executed instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (go_busy)
      cnt <= is_long && !rs_s ? CW'(LONG_BUSY - 1)
                              : CW'(SHORT_BUSY - 1);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  // blank-fill sequencer for reset and clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_on  <= 1'b1;
      fill_idx <= 5'd0;
    end else if (clr) begin
      fill_on  <= 1'b1;
      fill_idx <= 5'd0;
    end else if (fill_on) begin
      fill_idx <= fill_idx + 5'd1;
      if (fill_idx == 5'd31) fill_on <= 1'b0;
    end
  end

  // DDRAM write port: fill has priority
  always_ff @(posedge clk) begin
    if (fill_on)
      mem[fill_idx] <= 8'h20;
    else if (dwr && map_ok)
      mem[map_idx] <= din_s;
  end

  // registered display-content read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_char <= 8'h00;
    else     rd_char <= mem[rd_addr];
  end

  // instruction decode and address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt   <= 7'h00;
      inc_mode   <= 1'b1;
      shift_mode <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
    end else if (exec && !rs_s) begin
      unique casez (din_s)
        8'b1???????: addr_cnt <= din_s[6:0];
        8'b01??????: ;
        8'b001?????: two_line <= din_s[3];
        8'b0001????: begin
          if (!din_s[3])
            addr_cnt <= ac_step(addr_cnt, din_s[2]);
        end
        8'b00001???: begin
          disp_on   <= din_s[2];
          cursor_on <= din_s[1];
          blink_on  <= din_s[0];
        end
        8'b000001??: begin
          inc_mode   <= din_s[1];
          shift_mode <= din_s[0];
        end
        8'b0000001?: addr_cnt <= 7'h00;
        8'b00000001: begin
          addr_cnt <= 7'h00;
          inc_mode <= 1'b1;
        end
        default: ;
      endcase
    end else if (dwr || drd) begin
      addr_cnt <= ac_step(addr_cnt, inc_mode);
    end
  end

  // read-back data tracks the bus while e is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lcd_dout <= 8'h00;
    else if (e_s && rw_s)
      lcd_dout <= rs_s ? rd_data : {busy, addr_cnt};
  end

  // sticky overrun on any write strobe while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ovr_err <= 1'b0;
    else if (wr_stb && busy) ovr_err <= 1'b1;
  end

endmodule

// File: tb/tb_textlcd_responder.sv
// Directed self-checking bench for textlcd_responder.
// Bus cycles are driven slowly relative to clk.
module tb_textlcd_responder;

  localparam int SB = 6;
  localparam int LB = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_din = 8'h00;
  logic [7:0] lcd_dout;
  logic       lcd_doe;
  logic       busy;
  logic       disp_on, cursor_on, blink_on;
  logic       two_line, inc_mode, shift_mode;
  logic [6:0] addr_cnt;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       ovr_err;

  int checks = 0;
  int errors = 0;
  int run = 0;
  int last_run = 0;

  textlcd_responder #(
    .SHORT_BUSY(SB),
    .LONG_BUSY (LB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_din   (lcd_din),
    .lcd_dout  (lcd_dout),
    .lcd_doe   (lcd_doe),
    .busy      (busy),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .two_line  (two_line),
    .inc_mode  (inc_mode),
    .shift_mode(shift_mode),
    .addr_cnt  (addr_cnt),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .ovr_err   (ovr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic lcd_bus(input logic rs,
                         input logic rw,
                         input logic [7:0] d);
    lcd_rs  = rs;
    lcd_rw  = rw;
    lcd_din = d;
    tick(2);
    lcd_e = 1'b1;
    tick(4);
    lcd_e = 1'b0;
    tick(4);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 5000) begin
      tick(1);
      i++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
    tick(1);
  endtask

  task automatic lcd_wr(input logic rs, input logic [7:0] d);
    lcd_bus(rs, 1'b0, d);
    wait_idle();
  endtask

  task automatic lcd_read(input logic rs,
                          input logic [7:0] exp,
                          input string tag);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    tick(2);
    lcd_e = 1'b1;
    tick(6);
    check({tag, "_doe"}, 32'(lcd_doe), 1);
    check(tag, 32'(lcd_dout), 32'(exp));
    lcd_e = 1'b0;
    tick(4);
    lcd_rw = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a,
                        input logic [7:0] exp,
                        input string tag);
    rd_addr = a;
    tick(1);
    check(tag, 32'(rd_char), 32'(exp));
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_ac"}, 32'(addr_cnt), 0);
    check({tag, "_inc"}, 32'(inc_mode), 1);
    check({tag, "_modes"},
          32'({disp_on, cursor_on, blink_on, two_line, shift_mode}), 0);
    check({tag, "_ovr"}, 32'(ovr_err), 0);
    check({tag, "_doe"}, 32'(lcd_doe), 0);
    check({tag, "_dout"}, 32'(lcd_dout), 0);
    check({tag, "_rdch"}, 32'(rd_char), 0);
  endtask

  logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [7:0] world [5] = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

  initial begin
    tick(2);
    rst = 1'b1;
    #2;
    rst_chk("rst0");
    tick(3);
    rst = 1'b0;
    tick(31);
    check("fill_busy31", 32'(busy), 1);
    tick(2);
    check("fill_done_busy", 32'(busy), 0);
    check("fill_done_ac", 32'(addr_cnt), 0);
    for (int i = 0; i < 32; i++)
      rd_chk(5'(i), 8'h20, "init_blank");

    lcd_wr(1'b0, 8'h38);
    check("short_busy_len", last_run, SB);
    lcd_wr(1'b0, 8'h0C);
    lcd_wr(1'b0, 8'h06);
    lcd_wr(1'b0, 8'h80);
    for (int i = 0; i < 5; i++) lcd_wr(1'b1, hello[i]);
    check("two_line", 32'(two_line), 1);
    check("disp_cur_blk", 32'({disp_on, cursor_on, blink_on}), 3'b100);
    check("inc_shift", 32'({inc_mode, shift_mode}), 2'b10);
    check("hello_ac", 32'(addr_cnt), 5);
    for (int i = 0; i < 5; i++)
      rd_chk(5'(i), hello[i], "hello_char");
    rd_chk(5'd5, 8'h20, "hello_after");

    lcd_bus(1'b0, 1'b0, 8'h00);
    check("noop_busy", 32'(busy), 0);
    check("noop_ac", 32'(addr_cnt), 5);

    lcd_wr(1'b0, 8'hC0);
    lcd_wr(1'b0, 8'h04);
    for (int i = 0; i < 5; i++) lcd_wr(1'b1, world[i]);
    check("world_inc", 32'(inc_mode), 0);
    check("world_ac", 32'(addr_cnt), 7'h23);
    rd_chk(5'd16, 8'h57, "world_w");
    rd_chk(5'd17, 8'h20, "world_17");
    rd_chk(5'd15, 8'h20, "world_15");

    lcd_wr(1'b0, 8'h06);
    lcd_wr(1'b0, 8'hA7);
    lcd_wr(1'b1, 8'h41);
    check("wrap27_ac", 32'(addr_cnt), 7'h40);
    lcd_wr(1'b1, 8'h42);
    rd_chk(5'd16, 8'h42, "wrap27_e16");
    check("wrap27_ac2", 32'(addr_cnt), 7'h41);

    lcd_wr(1'b0, 8'h80);
    lcd_wr(1'b0, 8'h10);
    check("dec_wrap00", 32'(addr_cnt), 7'h67);
    lcd_wr(1'b0, 8'h14);
    check("inc_wrap67", 32'(addr_cnt), 7'h00);
    lcd_wr(1'b0, 8'hC0);
    lcd_wr(1'b0, 8'h10);
    check("dec_wrap40", 32'(addr_cnt), 7'h27);
    lcd_wr(1'b0, 8'h18);
    check("shift_noop", 32'(addr_cnt), 7'h27);

    lcd_wr(1'b0, 8'h80);
    lcd_read(1'b1, 8'h48, "dread_e0");
    check("dread_ac", 32'(addr_cnt), 1);
    lcd_read(1'b0, 8'h01, "status_idle");

    lcd_wr(1'b0, 8'h04);
    lcd_bus(1'b0, 1'b0, 8'h01);
    lcd_read(1'b0, 8'h80, "status_clr");
    check("pre_ovr", 32'(ovr_err), 0);
    lcd_bus(1'b1, 1'b0, 8'h55);
    check("ovr_set", 32'(ovr_err), 1);
    check("clr_still_busy", 32'(busy), 1);
    wait_idle();
    check("long_busy_len", last_run, LB);
    check("clr_ac", 32'(addr_cnt), 0);
    check("clr_inc", 32'(inc_mode), 1);
    check("ovr_sticky", 32'(ovr_err), 1);
    for (int i = 0; i < 32; i++)
      rd_chk(5'(i), 8'h20, "clr_blank");
    lcd_read(1'b0, 8'h00, "status_after_clr");

    lcd_wr(1'b0, 8'hCF);
    lcd_wr(1'b1, 8'h5A);
    rd_chk(5'd31, 8'h5A, "z_e31");
    lcd_bus(1'b0, 1'b0, 8'h01);
    tick(3);
    rst = 1'b1;
    #1;
    rst_chk("rst_mid");
    tick(2);
    rst = 1'b0;
    tick(10);
    check("refill_busy", 32'(busy), 1);
    tick(23);
    check("refill_done", 32'(busy), 0);
    rd_chk(5'd31, 8'h20, "refill_e31");
    rd_chk(5'd0, 8'h20, "refill_e0");
    check("refill_ovr", 32'(ovr_err), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_responder.md
TEXTLCD_RESPONDER -- requirements
Module: textlcd_responder

Interface
REQ-001 SHALL have parameter SHORT_BUSY, default 40, busy-time in clk cycles for ordinary instructions and data writes.
REQ-002 SHALL have parameter LONG_BUSY, default 1600, busy-time in clk cycles for clear-display and return-home (must be >= 32).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports lcd_e, lcd_rs, lcd_rw  input  1 each  HD44780-style bus from the host controller.
REQ-006 SHALL have port lcd_din  input  8  bus data driven by host.
REQ-007 SHALL have ports lcd_dout  output  8  and lcd_doe  output  1  read-back data and its output-enable.
REQ-008 SHALL have port busy  output  1  instruction-in-progress flag.
REQ-009 SHALL have ports disp_on, cursor_on, blink_on, two_line, inc_mode, shift_mode  output  1 each  decoded mode flags.
REQ-010 SHALL have port addr_cnt  output  7  current DDRAM address counter (AC).
REQ-011 SHALL have ports rd_addr  input  5  and rd_char  output  8  display-content read port (0-15 line 1, 16-31 line 2).
REQ-012 SHALL have port ovr_err  output  1  sticky flag: write strobe received while busy.

Function
REQ-013 SHALL pass lcd_e, lcd_rs, lcd_rw, lcd_din through two-flop synchronizers; all decoding uses synchronized values.
REQ-014 SHALL generate one-cycle strobe on synchronized lcd_e 1->0 transition; rs/rw/din sampled from the same synchronized stage in that cycle.
REQ-015 Write strobe (rw=0) while busy=0 SHALL be executed; busy SHALL rise the next cycle and stay high exactly SHORT_BUSY (or LONG_BUSY) cycles.
REQ-016 Write strobe while busy=1 SHALL be ignored and set ovr_err; ovr_err clears only on rst.
REQ-017 Instruction decode (rs=0) by highest set bit: 1aaaaaaa AC<=aaaaaaa; 01xxxxxx CGRAM-address, no effect except short busy; 001xNxxx two_line<=N; 0001SRxx if S=0 move AC +1 (R=1) or -1 (R=0), S=1 no-op; 00001DCB disp_on/cursor_on/blink_on<=D/C/B; 000001IS inc_mode<=I, shift_mode<=S; 0000001x AC<=0, long busy; 00000001 clear; 00000000 no-op, no busy.
REQ-018 Clear SHALL write 0x20 to all 32 DDRAM entries, one per cycle over 32 cycles, set AC<=0, inc_mode<=1, long busy.
REQ-019 Data write (rs=1, rw=0) SHALL store lcd_din at AC-mapped entry, then step AC per inc_mode; short busy.
REQ-020 AC mapping: 0x00-0x0F -> entries 0-15, 0x40-0x4F -> 16-31; other AC values store nothing but AC still steps.
REQ-021 AC increment SHALL wrap 0x27->0x40 and 0x67->0x00; decrement SHALL wrap 0x00->0x67 and 0x40->0x27; AC values 0x28-0x3F, 0x68-0x7F reachable only via set-address and step arithmetically modulo 128.
REQ-022 Status read (rs=0, rw=1) SHALL drive lcd_dout={busy, AC}, permitted regardless of busy.
REQ-023 Data read (rs=1, rw=1) SHALL drive lcd_dout=mapped entry at AC (0x20 if unmapped), then step AC per inc_mode on the strobe; ignored and no step if busy.
REQ-024 lcd_doe SHALL equal synchronized lcd_e AND synchronized lcd_rw; lcd_dout updates while lcd_e high.
REQ-025 rd_char SHALL be registered: value of entry rd_addr one cycle after rd_addr presented; rd_addr >= 32 impossible (5 bits).
REQ-026 Same-cycle DDRAM write and rd_addr read of the same entry SHALL return the old value.

Reset
REQ-027 On rst: busy=1, AC=0, inc_mode=1, disp_on=cursor_on=blink_on=two_line=shift_mode=0, ovr_err=0, lcd_doe=0, lcd_dout=0x00, rd_char=0x00, synchronizers cleared.
REQ-028 After rst release SHALL fill DDRAM with 0x20 over 32 cycles, then busy=0; strobes during the fill SHALL be treated as busy-writes.
REQ-029 rst asserted mid-instruction SHALL abort it and restart the REQ-028 fill.

Verification
REQ-030 Reset, wait 33 cycles: busy=0, rd_char=0x20 for every rd_addr, AC=0x00.
REQ-031 Write 0x38,0x0C,0x06 then data "HELLO" at 0x80: two_line=1, disp_on=1, inc_mode=1, entries 0-4 = 48 45 4C 4C 4F, AC=0x05.
REQ-032 Set AC 0xC0 (0x40), write "WORLD" with inc_mode=0 after 0x04: entries 16,.. at 0x40 then AC wraps to 0x27 -> only entry 16='W', AC=0x23 after 5 writes.
REQ-033 Set AC 0xA7 (0x27), write 0x41: AC=0x40; next write 0x42 lands in entry 16.
REQ-034 Issue 0x01, immediately status-read: lcd_dout[7]=1 for LONG_BUSY cycles, then all entries 0x20, AC=0; a write issued during busy sets ovr_err.
REQ-035 Assert rst during clear fill: outputs match REQ-027 in same cycle, fill restarts, ovr_err=0.
